// File: rtl/commit_trace_checker.sv
// Commit trace checker: buffers classified commit events from the core and
// compares them in order against an expected-record stream, tracking
// instruction/error counts and a pass/fail verdict at HALT or watchdog expiry.
module commit_trace_checker #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned WATCHDOG   = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cm_valid,
  input  logic [15:0] cm_pc,
  input  logic        cm_regwrite,
  input  logic        cm_memread,
  input  logic        cm_memwrite,
  input  logic        cm_halt,
  input  logic [3:0]  cm_reg,
  input  logic [15:0] cm_wdata,
  input  logic [15:0] cm_addr,
  input  logic [15:0] cm_mdata,
  input  logic        exp_valid,
  output logic        exp_ready,
  input  logic [1:0]  exp_kind,
  input  logic        exp_chk_addr,
  input  logic [15:0] exp_pc,
  input  logic [15:0] exp_value,
  input  logic [15:0] exp_addr,
  input  logic [3:0]  exp_reg,
  output logic [15:0] inst_count,
  output logic [15:0] err_count,
  output logic [15:0] first_err_inum,
  output logic        mismatch,
  output logic        overflow,
  output logic        timeout,
  output logic        done,
  output logic        pass
);

  localparam int unsigned AW  = $clog2(FIFO_DEPTH);
  localparam int unsigned PW  = AW + 1;
  localparam int unsigned WDW = $clog2(WATCHDOG) + 1;

  typedef enum logic [1:0] {K_NOP = 2'd0, K_REG = 2'd1, K_STORE = 2'd2, K_HALT = 2'd3} kind_e;
  typedef enum logic {S_RUN = 1'b0, S_DONE = 1'b1} state_e;

  // value holds wdata for REG and store data for STORE
  typedef struct packed {
    kind_e       kind;
    logic [15:0] pc;
    logic [3:0]  rd;
    logic [15:0] value;
    logic [15:0] addr;
  } entry_t;

  state_e          state_q, state_d;
  logic [PW-1:0]   wr_q, wr_d, rd_q, rd_d;
  logic [WDW-1:0]  wd_q, wd_d;
  logic [15:0]     inst_q, inst_d, err_q, err_d, first_q, first_d;
  logic            mismatch_q, mismatch_d, overflow_q, overflow_d, timeout_q, timeout_d;
  entry_t          mem_q [FIFO_DEPTH];
  entry_t          new_e, head;
  logic [PW-1:0]   occ;
  logic            run, empty, full, deq, enq_try, enq, drop, cmp_err;
  logic            unused_memread;

  // memread does not change the class; loads are told apart by exp_chk_addr
  assign unused_memread = cm_memread;

  assign run       = (state_q == S_RUN);
  assign occ       = wr_q - rd_q;
  assign empty     = (wr_q == rd_q);
  assign full      = (occ == PW'(FIFO_DEPTH));
  assign exp_ready = run & ~empty;
  assign deq       = exp_ready & exp_valid;
  assign enq_try   = cm_valid & run;
  // a same-cycle read frees a slot, so a full FIFO still accepts the write
  assign enq       = enq_try & (~full | deq);
  assign drop      = enq_try & full & ~deq;
  assign head      = mem_q[rd_q[AW-1:0]];

  // Classify the incoming commit with REG > HALT > STORE > NOP priority
  always_comb begin
    new_e    = '0;
    new_e.pc = cm_pc;
    if (cm_regwrite) begin
      new_e.kind  = K_REG;
      new_e.rd    = cm_reg;
      new_e.value = cm_wdata;
      new_e.addr  = cm_addr;
    end else if (cm_halt) begin
      new_e.kind = K_HALT;
    end else if (cm_memwrite) begin
      new_e.kind  = K_STORE;
      new_e.value = cm_mdata;
      new_e.addr  = cm_addr;
    end else begin
      new_e.kind = K_NOP;
    end
  end

  // Compare the FIFO head against the presented expected record
  always_comb begin
    cmp_err = (head.pc != exp_pc) || (head.kind != kind_e'(exp_kind));
    case (head.kind)
      K_REG: begin
        if ((head.rd != exp_reg) || (head.value != exp_value)) cmp_err = 1'b1;
        if (exp_chk_addr && (head.addr != exp_addr)) cmp_err = 1'b1;
      end
      K_STORE: begin
        if ((head.addr != exp_addr) || (head.value != exp_value)) cmp_err = 1'b1;
      end
      default: ;
    endcase
  end

  // Next state, pointers, watchdog and result counters
  always_comb begin
    state_d    = state_q;
    wr_d       = wr_q;
    rd_d       = rd_q;
    wd_d       = wd_q;
    inst_d     = inst_q;
    err_d      = err_q;
    first_d    = first_q;
    mismatch_d = mismatch_q;
    overflow_d = overflow_q;
    timeout_d  = timeout_q;

    if (enq) wr_d = wr_q + PW'(1);
    if (drop) overflow_d = 1'b1;

    if (deq) begin
      rd_d   = rd_q + PW'(1);
      inst_d = inst_q + 16'd1;
      if (cmp_err) begin
        if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
        if (!mismatch_q) first_d = inst_q;
        mismatch_d = 1'b1;
      end
      if ((head.kind == K_HALT) || (kind_e'(exp_kind) == K_HALT)) state_d = S_DONE;
    end

    if (enq) begin
      wd_d = '0;
    end else if (run) begin
      if (wd_q == WDW'(WATCHDOG - 1)) begin
        timeout_d = 1'b1;
        state_d   = S_DONE;
      end else begin
        wd_d = wd_q + WDW'(1);
      end
    end
  end

  // State and control registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_RUN;
      wr_q       <= '0;
      rd_q       <= '0;
      wd_q       <= '0;
      inst_q     <= '0;
      err_q      <= '0;
      first_q    <= '0;
      mismatch_q <= 1'b0;
      overflow_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      wd_q       <= wd_d;
      inst_q     <= inst_d;
      err_q      <= err_d;
      first_q    <= first_d;
      mismatch_q <= mismatch_d;
      overflow_q <= overflow_d;
      timeout_q  <= timeout_d;
    end
  end

  // FIFO storage; contents are qualified by the pointers so no reset is needed
  always_ff @(posedge clk) begin
    if (enq) mem_q[wr_q[AW-1:0]] <= new_e;
  end

  assign inst_count     = inst_q;
  assign err_count      = err_q;
  assign first_err_inum = first_q;
  assign mismatch       = mismatch_q;
  assign overflow       = overflow_q;
  assign timeout        = timeout_q;
  assign done           = (state_q == S_DONE);
  assign pass           = done & ~mismatch_q & ~overflow_q & ~timeout_q;

endmodule

// File: tb/tb_commit_trace_checker.sv
// Directed testbench for commit_trace_checker: main instance for trace
// checks, a second short-watchdog instance for timeout and async reset.
module tb_commit_trace_checker;

  logic        clk = 1'b0;
  logic        rst_n, rst_w;
  logic        cm_valid, cm_regwrite, cm_memread, cm_memwrite, cm_halt;
  logic [15:0] cm_pc, cm_wdata, cm_addr, cm_mdata;
  logic [3:0]  cm_reg;
  logic        exp_valid, exp_chk_addr;
  logic [1:0]  exp_kind;
  logic [15:0] exp_pc, exp_value, exp_addr;
  logic [3:0]  exp_reg;
  logic        exp_ready, mismatch, overflow, timeout, done, pass;
  logic [15:0] inst_count, err_count, first_err_inum;
  logic        w_exp_ready, w_mismatch, w_overflow, w_timeout, w_done, w_pass;
  logic [15:0] w_inst_count, w_err_count, w_first_err_inum;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  commit_trace_checker #(.FIFO_DEPTH(4), .WATCHDOG(1000)) dut (
    .clk(clk), .rst_n(rst_n), .cm_valid(cm_valid), .cm_pc(cm_pc),
    .cm_regwrite(cm_regwrite), .cm_memread(cm_memread), .cm_memwrite(cm_memwrite),
    .cm_halt(cm_halt), .cm_reg(cm_reg), .cm_wdata(cm_wdata), .cm_addr(cm_addr),
    .cm_mdata(cm_mdata), .exp_valid(exp_valid), .exp_ready(exp_ready),
    .exp_kind(exp_kind), .exp_chk_addr(exp_chk_addr), .exp_pc(exp_pc),
    .exp_value(exp_value), .exp_addr(exp_addr), .exp_reg(exp_reg),
    .inst_count(inst_count), .err_count(err_count), .first_err_inum(first_err_inum),
    .mismatch(mismatch), .overflow(overflow), .timeout(timeout), .done(done), .pass(pass)
  );

  commit_trace_checker #(.FIFO_DEPTH(4), .WATCHDOG(8)) dut_wd (
    .clk(clk), .rst_n(rst_w), .cm_valid(1'b0), .cm_pc(16'h0),
    .cm_regwrite(1'b0), .cm_memread(1'b0), .cm_memwrite(1'b0),
    .cm_halt(1'b0), .cm_reg(4'h0), .cm_wdata(16'h0), .cm_addr(16'h0),
    .cm_mdata(16'h0), .exp_valid(1'b0), .exp_ready(w_exp_ready),
    .exp_kind(2'd0), .exp_chk_addr(1'b0), .exp_pc(16'h0),
    .exp_value(16'h0), .exp_addr(16'h0), .exp_reg(4'h0),
    .inst_count(w_inst_count), .err_count(w_err_count), .first_err_inum(w_first_err_inum),
    .mismatch(w_mismatch), .overflow(w_overflow), .timeout(w_timeout), .done(w_done), .pass(w_pass)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cm(input logic [15:0] pc, input logic rw, input logic mr, input logic mw,
                        input logic hl, input logic [3:0] rg, input logic [15:0] wd,
                        input logic [15:0] ad, input logic [15:0] md);
    cm_valid = 1'b1; cm_pc = pc; cm_regwrite = rw; cm_memread = mr; cm_memwrite = mw;
    cm_halt = hl; cm_reg = rg; cm_wdata = wd; cm_addr = ad; cm_mdata = md;
  endtask

  task automatic idle_cm();
    cm_valid = 1'b0; cm_pc = '0; cm_regwrite = 1'b0; cm_memread = 1'b0; cm_memwrite = 1'b0;
    cm_halt = 1'b0; cm_reg = '0; cm_wdata = '0; cm_addr = '0; cm_mdata = '0;
  endtask

  task automatic set_exp(input logic [1:0] k, input logic ca, input logic [15:0] pc,
                         input logic [15:0] v, input logic [15:0] a, input logic [3:0] r);
    exp_valid = 1'b1; exp_kind = k; exp_chk_addr = ca; exp_pc = pc;
    exp_value = v; exp_addr = a; exp_reg = r;
  endtask

  task automatic do_reset();
    idle_cm();
    set_exp(2'd0, 1'b0, 16'h0, 16'h0, 16'h0, 4'h0);
    exp_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_w = 1'b0;
    do_reset();

    // Reset state
    chk("rst_inst", inst_count, 0);
    chk("rst_err", err_count, 0);
    chk("rst_first", first_err_inum, 0);
    chk("rst_flags", {mismatch, overflow, timeout, done, pass}, 5'b0);
    chk("rst_ready", exp_ready, 0);

    // Clean run: REG, STORE, HALT back to back
    set_cm(16'h0000, 1, 0, 0, 0, 4'd1, 16'h0005, 16'h0, 16'h0);
    set_exp(2'd1, 0, 16'h0000, 16'h0005, 16'h0, 4'd1);
    tick();
    chk("t1_ready", exp_ready, 1);
    set_cm(16'h0002, 0, 0, 1, 0, 4'd0, 16'h0, 16'h0010, 16'h0005);
    tick();
    set_cm(16'h0004, 0, 0, 0, 1, 4'd0, 16'h0, 16'h0, 16'h0);
    set_exp(2'd2, 0, 16'h0002, 16'h0005, 16'h0010, 4'd0);
    tick();
    chk("t1_done_early", done, 0);
    idle_cm();
    set_exp(2'd3, 0, 16'h0004, 16'h0, 16'h0, 4'd0);
    tick();
    chk("t1_inst", inst_count, 3);
    chk("t1_err", err_count, 0);
    chk("t1_done", done, 1);
    chk("t1_pass", pass, 1);
    chk("t1_ready_done", exp_ready, 0);

    // Data mismatch on the second instruction
    do_reset();
    set_cm(16'h0000, 1, 0, 0, 0, 4'd1, 16'h0005, 16'h0, 16'h0);
    set_exp(2'd1, 0, 16'h0000, 16'h0005, 16'h0, 4'd1);
    tick();
    set_cm(16'h0002, 1, 0, 0, 0, 4'd2, 16'h0006, 16'h0, 16'h0);
    tick();
    set_cm(16'h0004, 0, 0, 0, 1, 4'd0, 16'h0, 16'h0, 16'h0);
    set_exp(2'd1, 0, 16'h0002, 16'h0005, 16'h0, 4'd2);
    tick();
    idle_cm();
    set_exp(2'd3, 0, 16'h0004, 16'h0, 16'h0, 4'd0);
    tick();
    chk("t2_mismatch", mismatch, 1);
    chk("t2_err", err_count, 1);
    chk("t2_first", first_err_inum, 1);
    chk("t2_inst", inst_count, 3);
    chk("t2_done", done, 1);
    chk("t2_pass", pass, 0);

    // Backpressure: four commits fill the FIFO, the fifth is dropped
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_cm(16'(i * 2), 0, 0, 0, 0, 4'd0, 16'h0, 16'h0, 16'h0);
      tick();
    end
    chk("t3_ready_full", exp_ready, 1);
    chk("t3_ovf_before", overflow, 0);
    set_cm(16'h0008, 0, 0, 0, 0, 4'd0, 16'h0, 16'h0, 16'h0);
    tick();
    chk("t3_ovf", overflow, 1);
    idle_cm();
    for (int i = 0; i < 4; i++) begin
      set_exp(2'd0, 0, 16'(i * 2), 16'h0, 16'h0, 4'd0);
      tick();
    end
    chk("t3_inst", inst_count, 4);
    chk("t3_err", err_count, 0);
    chk("t3_empty", exp_ready, 0);
    tick();
    chk("t3_inst_hold", inst_count, 4);

    // Full FIFO with simultaneous enqueue and dequeue
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_cm(16'(i * 2), 0, 0, 0, 0, 4'd0, 16'h0, 16'h0, 16'h0);
      tick();
    end
    set_cm(16'h0008, 0, 0, 0, 0, 4'd0, 16'h0, 16'h0, 16'h0);
    set_exp(2'd0, 0, 16'h0000, 16'h0, 16'h0, 4'd0);
    tick();
    chk("t4_ovf", overflow, 0);
    chk("t4_inst", inst_count, 1);
    idle_cm();
    for (int i = 1; i < 5; i++) begin
      set_exp(2'd0, 0, 16'(i * 2), 16'h0, 16'h0, 4'd0);
      tick();
    end
    chk("t4_inst_drain", inst_count, 5);
    chk("t4_err", err_count, 0);
    chk("t4_empty", exp_ready, 0);
    tick();
    chk("t4_inst_hold", inst_count, 5);

    // Load with wrong address, then REG-over-HALT priority
    do_reset();
    set_cm(16'h0000, 1, 1, 0, 0, 4'd3, 16'h0007, 16'h0020, 16'h0);
    set_exp(2'd1, 1, 16'h0000, 16'h0007, 16'h0024, 4'd3);
    tick();
    set_cm(16'h0002, 1, 0, 0, 1, 4'd4, 16'h0009, 16'h0, 16'h0);
    tick();
    set_cm(16'h0004, 0, 0, 0, 1, 4'd0, 16'h0, 16'h0, 16'h0);
    set_exp(2'd1, 0, 16'h0002, 16'h0009, 16'h0, 4'd4);
    tick();
    chk("t5_load_mm", mismatch, 1);
    chk("t5_err_1", err_count, 1);
    chk("t5_prio_not_done", done, 0);
    chk("t5_inst_2", inst_count, 2);
    idle_cm();
    set_exp(2'd3, 0, 16'h0004, 16'h0, 16'h0, 4'd0);
    tick();
    chk("t5_first", first_err_inum, 0);
    chk("t5_err_final", err_count, 1);
    chk("t5_done", done, 1);
    chk("t5_pass", pass, 0);
    exp_valid = 1'b0;

    // Watchdog expiry on the WATCHDOG=8 instance, then async reset
    rst_w = 1'b1;
    repeat (7) tick();
    chk("t6_to_early", w_timeout, 0);
    chk("t6_done_early", w_done, 0);
    tick();
    chk("t6_timeout", w_timeout, 1);
    chk("t6_done", w_done, 1);
    chk("t6_pass", w_pass, 0);
    tick();
    chk("t6_done_hold", w_done, 1);
    #3;
    rst_w = 1'b0;
    #1;
    chk("t6_rst_flags", {w_mismatch, w_overflow, w_timeout, w_done, w_pass, w_exp_ready}, 6'b0);
    chk("t6_rst_counts", {w_inst_count, w_err_count}, 32'h0);
    chk("t6_rst_first", w_first_err_inum, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/commit_trace_checker.md
# commit_trace_checker

Hardware trace checker that sits beside the `cpu` core in simulation and FPGA self-test builds. It consumes the core's per-instruction commit events and compares each one, in order, against an expected-trace record stream supplied through a valid/ready handshake. Commits are classified with the same REG / HALT / STORE / NOP priority used to produce golden traces. The block counts instructions and mismatches, latches the first failing instruction number, and signals pass/fail once HALT retires or the watchdog expires.

## Interface
- `FIFO_DEPTH`, 4: commit-event buffer entries (power of two, ≥2).
- `WATCHDOG`, 100000: max cycles without a commit before timeout.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `cm_valid` in 1: a commit event is present this cycle.
- `cm_pc` in 16: PC of the committing instruction.
- `cm_regwrite`, `cm_memread`, `cm_memwrite`, `cm_halt` in 1 each: commit control flags.
- `cm_reg` in 4: destination register.
- `cm_wdata` in 16: register write data.
- `cm_addr` in 16: memory address (ALU result).
- `cm_mdata` in 16: store data.
- `exp_valid` in 1 / `exp_ready` out 1: expected-record handshake.
- `exp_kind` in 2: 0 = NOP/branch, 1 = REG, 2 = STORE, 3 = HALT.
- `exp_chk_addr` in 1: REG record is a load; also compare the address.
- `exp_pc`, `exp_value`, `exp_addr` in 16 each; `exp_reg` in 4.
- `inst_count` out 16: records compared so far.
- `err_count` out 16: mismatching records, saturating at 0xFFFF.
- `first_err_inum` out 16: inst_count value of the first mismatch.
- `mismatch` out 1: sticky; at least one error seen.
- `overflow` out 1: sticky; a commit arrived while the FIFO was full.
- `timeout` out 1: sticky; watchdog expired.
- `done` out 1: checking finished.
- `pass` out 1: `done` with no mismatch, overflow, or timeout.

## Operation
- Classification at enqueue uses this priority: `cm_regwrite` → REG; else `cm_halt` → HALT; else `cm_memwrite` → STORE; else NOP. Only the class and the relevant fields are stored.
- Enqueue happens when `cm_valid` is high and state is RUN. If the FIFO is full, the event is dropped and `overflow` is set.
- Dequeue/compare happens when the FIFO is non-empty, `exp_valid` is high, and state is RUN. `exp_ready` = FIFO non-empty and state is RUN. One record is compared per cycle.
- Compare rules:
  - PC and class are compared for every class.
  - REG also compares register and `wdata`; when `exp_chk_addr` is set, it also compares `addr`.
  - STORE also compares `addr` and `mdata`.
  - NOP and HALT compare nothing further.
- On mismatch: `err_count` is incremented (saturating). If `mismatch` was 0, `first_err_inum` is loaded with the current `inst_count`. `mismatch` is then set.
- `inst_count` increments once per compare, wrapping at 16 bits.
- States:
  - RUN → DONE when the compared record has commit class HALT or expected class HALT.
  - RUN → DONE when the watchdog expires.
  - DONE holds until reset. Nothing is enqueued or compared, and `exp_ready` = 0.
- Watchdog counter:
  - Clears on any enqueue.
  - Increments in RUN otherwise.
  - At `WATCHDOG`-1 it sets `timeout` and moves to DONE.
- Simultaneous enqueue and dequeue is allowed when full. Occupancy is unchanged and nothing is dropped; the write is accepted because the read frees a slot in the same cycle.

## Timing
- Reset values: all counters 0; all flags 0; FIFO empty; state RUN; `exp_ready` 0.
- Enqueue-to-compare latency is minimum 1 cycle: an event captured at edge N can be compared at edge N+1 if `exp_valid` is high.
- `exp_ready` is combinational from registered state only. It has no path from `exp_*` inputs.
- Compare results, counters, and flags update on the compare edge.
- `done` asserts in the cycle after the HALT compare edge. `pass` is valid whenever `done` = 1.
- Assertion of `rst_n` mid-operation clears everything immediately, independent of `clk`.

## Test plan
- **Clean run:** three commits in back-to-back cycles with matching records:
  - REG r1 = 0x0005, PC 0x0000.
  - STORE addr 0x0010 data 0x0005, PC 0x0002.
  - HALT, PC 0x0004.
  - Required: `inst_count` = 3, `err_count` = 0, `done` = 1, `pass` = 1.
- **Data mismatch:** a REG commit with wdata 0x0006 against an expected record of 0x0005, as the second instruction. Required: `mismatch` = 1, `err_count` = 1, `first_err_inum` = 1, `pass` = 0 after HALT.
- **Backpressure:** hold `exp_valid` low while 4 commits arrive, then a fifth. Required: FIFO full, `overflow` = 1, and 4 records compared once `exp_valid` rises.
- **Full + simultaneous:** with the FIFO full, present a commit and `exp_valid` in the same cycle. Required: both accepted, `overflow` stays 0, occupancy stays 4.
- **Load and priority:**
  - A commit with both `cm_regwrite` and `cm_memread` against a REG record with `exp_chk_addr` = 1 and a wrong addr. Required: a mismatch is flagged.
  - A commit with both `cm_regwrite` and `cm_halt` set. Required: it is classified as REG.
- **Watchdog and reset:**
  - With `WATCHDOG` = 8 and no commits. Required: `timeout` = 1 and `done` = 1 at cycle 8, `pass` = 0.
  - Then assert `rst_n` low mid-cycle. Required: all outputs return to 0 immediately.
